// File: rtl/mem_pkg.sv
// Shared types and byte-enable constants for the data-memory handler.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } mem_state_t;

    localparam logic [3:0] SEL_WORD  = 4'b1111;
    localparam logic [3:0] SEL_BYTE0 = 4'b0001;

endpackage

// File: rtl/byte_lane_steer.sv
// Byte-lane steering: store byte enables/replicated data and lb sign extension.
// Purely combinational; no latency, no flow control.
import mem_pkg::*;

module byte_lane_steer (
    input  logic [1:0]  lane,
    input  logic        is_write,
    input  logic        load_byte,
    input  logic        store_byte,
    input  logic [31:0] write_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_val
);

    logic       byte_op;
    logic [7:0] rbyte;

    always_comb begin
        byte_op   = is_write ? store_byte : load_byte;
        bus_sel   = byte_op ? (SEL_BYTE0 << lane) : SEL_WORD;
        bus_wdata = store_byte ? {4{write_data[7:0]}} : write_data;
        rbyte     = bus_rdata[8*lane +: 8];
        load_val  = load_byte ? {{24{rbyte[7]}}, rbyte} : bus_rdata;
    end

endmodule

// File: rtl/data_mem_handler.sv
// Memory-stage load/store bus sequencer: min 3 cycles (request, strobe, done),
// stalls upstream until bus_ack or TIMEOUT strobe cycles elapse.
import mem_pkg::*;

module data_mem_handler #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_mem,
    input  logic              write_mem,
    input  logic              load_byte,
    input  logic              store_byte,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] reg_data_out,
    output logic              stall,
    output logic              bus_error,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    output logic              bus_read,
    output logic              bus_write,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    mem_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    lane_q, lane;
    logic          lb_q, lb;
    logic          timeout;
    logic [3:0]    sel_w;
    logic [31:0]   wdata_w;
    logic [31:0]   load_val;

    // Lane/width come from live inputs while accepting, from the latched copy afterwards.
    assign lane    = (state == IDLE) ? addr[1:0] : lane_q;
    assign lb      = (state == IDLE) ? load_byte : lb_q;
    assign timeout = (cnt == LAST);

    byte_lane_steer u_steer (
        .lane       (lane),
        .is_write   (write_mem),
        .load_byte  (lb),
        .store_byte (store_byte),
        .write_data (write_data),
        .bus_rdata  (bus_rdata),
        .bus_sel    (sel_w),
        .bus_wdata  (wdata_w),
        .load_val   (load_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = read_mem | write_mem;
                if (write_mem)     state_nxt = WRITE;
                else if (read_mem) state_nxt = READ;
            end
            READ, WRITE: begin
                stall = 1'b1;
                if (bus_ack || timeout) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            lane_q       <= '0;
            lb_q         <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_sel      <= '0;
            bus_read     <= 1'b0;
            bus_write    <= 1'b0;
            bus_error    <= 1'b0;
            reg_data_out <= '0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (write_mem || read_mem) begin
                        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_wdata <= wdata_w;
                        bus_sel   <= sel_w;
                        bus_write <= write_mem;
                        bus_read  <= ~write_mem;
                        lane_q    <= addr[1:0];
                        lb_q      <= load_byte;
                    end
                end
                READ, WRITE: begin
                    if (bus_ack) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        cnt       <= '0;
                        if (state == READ) reg_data_out <= load_val;
                    end else if (timeout) begin
                        bus_read     <= 1'b0;
                        bus_write    <= 1'b0;
                        bus_error    <= 1'b1;
                        reg_data_out <= '0;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/data_mem_handler.md
# data_mem_handler

Sequential responder for the memory control signals produced by the instruction decoder (read_mem, write_mem, load_byte, store_byte). It sits in the memory stage between the ALU result / rs2 operand and the external data bus. It converts a decoded load or store into a bus request/acknowledge transaction, stalls the pipeline until the transaction completes, and performs byte-lane steering and lb sign extension.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32; byte lanes assume 4 lanes)
- TIMEOUT, 16, cycles to wait for bus_ack before abort (≥2)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- read_mem  in  1  decoded load request
- write_mem  in  1  decoded store request
- load_byte  in  1  load is lb (else lw)
- store_byte  in  1  store is sb (else sw)
- addr  in  ADDR_W  effective address (ALU result)
- write_data  in  DATA_W  store operand (rs2)
- reg_data_out  out  DATA_W  load result to writeback, registered
- stall  out  1  freeze upstream pipeline
- bus_error  out  1  one-cycle pulse on timeout abort
- bus_addr  out  ADDR_W  word-aligned bus address, registered
- bus_wdata  out  DATA_W  bus write data, registered
- bus_sel  out  4  byte enables, registered
- bus_read  out  1  read strobe, held until ack
- bus_write  out  1  write strobe, held until ack
- bus_rdata  in  DATA_W  bus read data, valid with bus_ack
- bus_ack  in  1  bus completion, one cycle

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_mem=1 → latch addr, data and flags; go to WRITE.
  - Else read_mem=1 → latch; go to READ.
  - write_mem and read_mem together: write wins; the read is dropped.
- READ/WRITE:
  - The strobe is asserted and the timeout counter runs.
  - bus_ack → DONE. READ also captures the steered rdata into reg_data_out.
  - Counter reaches TIMEOUT-1 with no ack → drop strobe, pulse bus_error, set reg_data_out=0, go to DONE.
- DONE: one cycle. stall=0. read_mem/write_mem are ignored, because the same instruction is still presented. Next state is IDLE.
- stall is combinational:
  - 1 in IDLE when read_mem|write_mem.
  - 1 throughout READ and WRITE.
  - 0 in DONE and in IDLE with no request.
- bus_addr = {addr[ADDR_W-1:2], 2'b00}.
- Word store: bus_sel=4'b1111, bus_wdata=write_data. Misaligned addr[1:0] is ignored.
- Byte store: bus_sel = 4'b0001 << addr[1:0], bus_wdata = {4{write_data[7:0]}}.
- Word load: reg_data_out = bus_rdata.
- Byte load: select lane addr[1:0] (lane 0 = bits 7:0) and sign-extend bit 7 to 32 bits.
- Reset (any time, including mid-transaction):
  - State IDLE.
  - bus_read=bus_write=0, bus_sel=0, bus_addr=0, bus_wdata=0.
  - reg_data_out=0, bus_error=0, stall=0, counter=0.
  - No ack is awaited after reset release.
- An ack arriving in IDLE or DONE is ignored.

## Timing
- Cycle 0: request seen in IDLE. stall=1; bus fields registered at the edge.
- Cycle 1: bus_read/bus_write high. An ack in cycle 1 is the fastest completion.
- Ack in cycle k → DONE in cycle k+1, reg_data_out valid from k+1, stall=0 in k+1.
- Minimum load/store latency is 3 cycles (IDLE, strobe, DONE), with 2 stalled cycles.
- Timeout: strobe high for exactly TIMEOUT cycles, then bus_error high for 1 cycle in the first DONE cycle.
- reg_data_out holds its value until the next completed read or timeout.

## Structure
- Shared package mem_pkg: state enum mem_state_t {IDLE, READ, WRITE, DONE}, SEL_WORD=4'b1111, SEL_BYTE0=4'b0001.
- One combinational sub-module, byte_lane_steer: given addr[1:0], the byte flags, write_data and bus_rdata, it produces bus_sel, bus_wdata and the extended load value.
- The top holds the FSM, timeout counter and output registers.

## Test plan
- Reset asserted during READ → strobes drop the same cycle without waiting for a clock. After release: IDLE, stall=0, all outputs 0.
- sw addr=0x1006, data=0xDEADBEEF, ack after 2 cycles → bus_addr=0x1004, bus_sel=1111, wdata=0xDEADBEEF, write strobe 2 cycles, stall 3 cycles.
- lb addr=0x2003, rdata=0x80FF7F01, immediate ack → reg_data_out=0xFFFFFF80; repeat with addr=0x2000 → 0x00000001.
- sb addr=0x13, data=0x000000AB → bus_sel=1000, bus_wdata=0xABABABAB.
- read_mem=write_mem=1 in IDLE → only bus_write asserted; held request in DONE does not re-issue.
- No ack with TIMEOUT=16 → bus_read high 16 cycles, bus_error 1-cycle pulse, reg_data_out=0, back to IDLE.
